// File: rtl/pov_hand_renderer_if.sv
// Signal bundle between time_counter / index sensor and the POV hand renderer.
// Latency: none (wires only). Backpressure: none, all signals are levels or pulses.
interface pov_hand_renderer_if #(
   parameter int LED_COUNT = 16,
   parameter int COL_W     = 6,
   parameter int PERIOD_W  = 24
);
   logic                 index_in;
   logic [5:0]           curr_hours;
   logic [6:0]           curr_minutes;
   logic [6:0]           curr_seconds;
   logic [LED_COUNT-1:0] led_col;
   logic [COL_W-1:0]     col_idx;
   logic                 stalled;
   logic [PERIOD_W-1:0]  rev_period;

   modport master (
      output index_in, curr_hours, curr_minutes, curr_seconds,
      input  led_col, col_idx, stalled, rev_period
   );

   modport slave (
      input  index_in, curr_hours, curr_minutes, curr_seconds,
      output led_col, col_idx, stalled, rev_period
   );
endinterface

// File: rtl/pov_hand_renderer.sv
// POV clock hands: times the index pulse, splits a revolution into columns, drives LEDs (TICK_MARKS_EN adds 5-column marks).
// Latency: index edge acts 3 cycles after raw rise; led_col follows col_idx by 1 cycle.
// Backpressure: none; free-running, blanks after STALL_TIMEOUT cycles without an accepted edge.
module pov_hand_renderer #(
   parameter int NUM_COLS   = 60,
   parameter int COL_W      = 6,
   parameter int LED_COUNT  = 16,
   parameter int MIN_LEN    = 14,
   parameter int HOUR_LEN   = 10,
   parameter int PERIOD_W   = 24,
   parameter int MIN_PERIOD = 1000,
   parameter logic [PERIOD_W-1:0] STALL_TIMEOUT = 24'd10000000
) (
   input  logic sys_clk,
   input  logic rst_n,
   pov_hand_renderer_if.slave bus
);
   localparam int CNT_W = $clog2(PERIOD_W + 1);
   localparam logic [LED_COUNT-1:0] ALL_ON    = '1;
   localparam logic [LED_COUNT-1:0] MIN_MASK  = ALL_ON >> (LED_COUNT - MIN_LEN);
   localparam logic [LED_COUNT-1:0] HOUR_MASK = ALL_ON >> (LED_COUNT - HOUR_LEN);

   typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, RUN = 2'd2} state_t;

   state_t               state_q;
   logic                 stalled_q;
   logic [2:0]           idx_sync_q;
   logic                 edge_det, accept, stall_hit, div_last, div_ge;
   logic [PERIOD_W:0]    period_inc, div_shift;
   logic [PERIOD_W-1:0]  period_cnt_q, period_cnt_d;
   logic [PERIOD_W-1:0]  rev_period_q, rev_period_d;
   logic [5:0]           snap_h_q, snap_h_d;
   logic [6:0]           snap_m_q, snap_m_d, snap_s_q, snap_s_d;
   logic [COL_W-1:0]     col_idx_q, col_idx_d;
   logic [PERIOD_W-1:0]  col_tmr_q, col_tmr_d;
   logic [PERIOD_W-1:0]  col_width_q, col_width_d;
   logic [PERIOD_W-1:0]  col_act_q, col_act_d;
   logic                 div_busy_q, div_busy_d;
   logic [CNT_W-1:0]     div_cnt_q, div_cnt_d;
   logic [PERIOD_W-1:0]  div_rem_q, div_rem_d, div_quo_q, div_quo_d;
   logic [PERIOD_W-1:0]  div_sub, div_quo_nxt;
   logic [LED_COUNT-1:0] led_q, led_d;
   logic [5:0]           h12;
   logic [6:0]           m_cl, s_cl, hour_col, col_ext;

   assign edge_det   = idx_sync_q[1] & ~idx_sync_q[2];
   assign period_inc = {1'b0, period_cnt_q} + (PERIOD_W+1)'(1);
   // Anything closer than MIN_PERIOD to the last accepted edge is a glitch, except when nothing is being tracked.
   assign accept     = edge_det && ((state_q == IDLE) || (period_inc >= (PERIOD_W+1)'(MIN_PERIOD)));
   assign stall_hit  = !accept && (state_q != IDLE) && (period_cnt_q == STALL_TIMEOUT);

   assign div_shift   = {div_rem_q, div_quo_q[PERIOD_W-1]};
   assign div_ge      = div_shift >= (PERIOD_W+1)'(NUM_COLS);
   assign div_sub     = div_shift[PERIOD_W-1:0] - PERIOD_W'(NUM_COLS);
   assign div_quo_nxt = {div_quo_q[PERIOD_W-2:0], div_ge};
   assign div_last    = div_busy_q && (div_cnt_q == CNT_W'(1));

   always_comb begin
      period_cnt_d = period_cnt_q;
      rev_period_d = rev_period_q;
      snap_h_d     = snap_h_q;
      snap_m_d     = snap_m_q;
      snap_s_d     = snap_s_q;
      col_idx_d    = col_idx_q;
      col_tmr_d    = col_tmr_q;
      col_width_d  = col_width_q;
      col_act_d    = col_act_q;
      div_busy_d   = div_busy_q;
      div_cnt_d    = div_cnt_q;
      div_rem_d    = div_rem_q;
      div_quo_d    = div_quo_q;

      if (accept)
         period_cnt_d = '0;
      else if (period_cnt_q != STALL_TIMEOUT)
         period_cnt_d = period_inc[PERIOD_W-1:0];

      if (div_busy_q) begin
         div_rem_d = div_ge ? div_sub : div_shift[PERIOD_W-1:0];
         div_quo_d = div_quo_nxt;
         div_cnt_d = div_cnt_q - CNT_W'(1);
         if (div_last) begin
            div_busy_d  = 1'b0;
            col_width_d = (div_quo_nxt == '0) ? PERIOD_W'(1) : div_quo_nxt;
            if (state_q == MEASURE)
               col_act_d = col_width_d;
         end
      end

      if (accept) begin
         snap_h_d  = bus.curr_hours;
         snap_m_d  = bus.curr_minutes;
         snap_s_d  = bus.curr_seconds;
         col_idx_d = '0;
         col_tmr_d = '0;
         col_act_d = col_width_q;
         if (state_q != IDLE) begin
            rev_period_d = period_inc[PERIOD_W-1:0];
            div_busy_d   = 1'b1;
            div_cnt_d    = CNT_W'(PERIOD_W);
            div_rem_d    = '0;
            div_quo_d    = period_inc[PERIOD_W-1:0];
         end
      end else if (state_q == RUN) begin
         // A freshly divided width is only picked up at a column boundary.
         if (col_tmr_q == col_act_q - PERIOD_W'(1)) begin
            col_tmr_d = '0;
            col_act_d = col_width_q;
            if (col_idx_q != COL_W'(NUM_COLS - 1))
               col_idx_d = col_idx_q + COL_W'(1);
         end else begin
            col_tmr_d = col_tmr_q + PERIOD_W'(1);
         end
      end
   end

   always_comb begin
      if (snap_h_q >= 6'd24)
         h12 = '0;
      else if (snap_h_q >= 6'd12)
         h12 = snap_h_q - 6'd12;
      else
         h12 = snap_h_q;
      m_cl     = (snap_m_q > 7'd59) ? 7'd59 : snap_m_q;
      s_cl     = (snap_s_q > 7'd59) ? 7'd59 : snap_s_q;
      hour_col = {1'b0, h12} * 7'd5 + m_cl / 7'd12;
      col_ext  = 7'(col_idx_q);

      led_d = '0;
      if (state_q == RUN) begin
         if (col_ext == s_cl)
            led_d = led_d | ALL_ON;
         if (col_ext == m_cl)
            led_d = led_d | MIN_MASK;
         if (col_ext == hour_col)
            led_d = led_d | HOUR_MASK;
`ifdef TICK_MARKS_EN
         if ((col_ext % 7'd5) == 7'd0)
            led_d[LED_COUNT-1] = 1'b1;
`endif
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         stalled_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q   <= MEASURE;
                  stalled_q <= 1'b0;
               end
            end
            MEASURE: begin
               if (stall_hit) begin
                  state_q   <= IDLE;
                  stalled_q <= 1'b1;
               end else if (div_last) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (stall_hit) begin
                  state_q   <= IDLE;
                  stalled_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               stalled_q <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_sync_q   <= '0;
         period_cnt_q <= '0;
         rev_period_q <= '0;
         snap_h_q     <= '0;
         snap_m_q     <= '0;
         snap_s_q     <= '0;
         col_idx_q    <= '0;
         col_tmr_q    <= '0;
         col_width_q  <= '0;
         col_act_q    <= '0;
         div_busy_q   <= 1'b0;
         div_cnt_q    <= '0;
         div_rem_q    <= '0;
         div_quo_q    <= '0;
         led_q        <= '0;
      end else begin
         idx_sync_q   <= {idx_sync_q[1:0], bus.index_in};
         period_cnt_q <= period_cnt_d;
         rev_period_q <= rev_period_d;
         snap_h_q     <= snap_h_d;
         snap_m_q     <= snap_m_d;
         snap_s_q     <= snap_s_d;
         col_idx_q    <= col_idx_d;
         col_tmr_q    <= col_tmr_d;
         col_width_q  <= col_width_d;
         col_act_q    <= col_act_d;
         div_busy_q   <= div_busy_d;
         div_cnt_q    <= div_cnt_d;
         div_rem_q    <= div_rem_d;
         div_quo_q    <= div_quo_d;
         led_q        <= led_d;
      end
   end

   assign bus.led_col    = led_q;
   assign bus.col_idx    = col_idx_q;
   assign bus.stalled    = stalled_q;
   assign bus.rev_period = rev_period_q;
endmodule

// File: tb/tb_pov_hand_renderer.sv
// Directed bench for pov_hand_renderer: expected column patterns go into a queue, a negedge monitor checks them.
module tb_pov_hand_renderer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pov_hand_renderer_if #(.LED_COUNT(16), .COL_W(6), .PERIOD_W(24)) bus ();

   pov_hand_renderer #(.STALL_TIMEOUT(24'd15000)) dut (
      .sys_clk (clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

`ifdef TICK_MARKS_EN
   localparam bit TICKS = 1'b1;
`else
   localparam bit TICKS = 1'b0;
`endif

   typedef struct {
      int          col;
      logic [15:0] pat;
   } exp_t;

   exp_t sbq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] tk(input int c);
      return (TICKS && (c % 5 == 0)) ? 16'h8000 : 16'h0000;
   endfunction

   task automatic push(input int c, input logic [15:0] base);
      exp_t e;
      e.col = c;
      e.pat = base | tk(c);
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_hi();
      bus.index_in = 1'b1;
      idle(4);
      bus.index_in = 1'b0;
   endtask

   task automatic set_time(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
      bus.curr_hours   = h;
      bus.curr_minutes = m;
      bus.curr_seconds = s;
   endtask

   // Monitor: once a column has been stable for a few cycles its registered pattern is settled.
   int         stable = 0;
   logic [5:0] last_col = '0;
   logic       last_st = 1'b1;
   always @(negedge clk) begin
      if (!rst_n || bus.col_idx != last_col || bus.stalled != last_st)
         stable = 0;
      else if (stable < 10)
         stable = stable + 1;
      last_col = bus.col_idx;
      last_st  = bus.stalled;
      if (rst_n && !bus.stalled && stable >= 3 && sbq.size() > 0) begin
         if (int'(bus.col_idx) == sbq[0].col) begin
            check($sformatf("led_col@col%0d", sbq[0].col), 32'(bus.led_col), 32'(sbq[0].pat));
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      bus.index_in = 1'b0;
      set_time(6'd3, 7'd0, 7'd30);
      idle(3);
      check("reset_led_col", 32'(bus.led_col), 32'h0);
      check("reset_col_idx", 32'(bus.col_idx), 32'h0);
      check("reset_stalled", 32'(bus.stalled), 32'h1);
      check("reset_rev_period", 32'(bus.rev_period), 32'h0);
      rst_n = 1'b1;
      idle(20);

      // R0: first edge, IDLE -> MEASURE
      pulse_hi();
      idle(5996);

      // R1: second edge, period measured, RUN after divide
      pulse_hi();
      idle(46);
      check("rev_period_r1", 32'(bus.rev_period), 32'd6000);
      push(0, 16'h3FFF);
      push(1, 16'h0000);
      push(5, 16'h0000);
      push(15, 16'h03FF);
      push(30, 16'hFFFF);
      idle(5950);

      // R2: glitch at +500, time changes mid-revolution without tearing
      push(0, 16'h3FFF);
      push(5, 16'h0000);
      push(15, 16'h03FF);
      push(30, 16'hFFFF);
      push(59, 16'h0000);
      pulse_hi();
      idle(496);
      pulse_hi();
      idle(446);
      check("glitch_col_idx", 32'(bus.col_idx), 32'd9);
      check("glitch_rev_period", 32'(bus.rev_period), 32'd6000);
      set_time(6'd24, 7'd59, 7'd59);
      idle(5050);

      // R3: 24:59:59 snapshot, then pulses stop
      push(0, 16'h0000);
      push(4, 16'h03FF);
      push(30, 16'h0000);
      push(59, 16'hFFFF);
      pulse_hi();
      idle(6496);
      check("col_idx_saturate", 32'(bus.col_idx), 32'd59);
      idle(8400);
      check("pre_stall_stalled", 32'(bus.stalled), 32'h0);
      idle(120);
      check("stall_stalled", 32'(bus.stalled), 32'h1);
      check("stall_led_col", 32'(bus.led_col), 32'h0);
      set_time(6'd3, 7'd0, 7'd30);
      idle(80);

      // R5: restart, MEASURE stays blank
      pulse_hi();
      idle(96);
      check("restart_stalled", 32'(bus.stalled), 32'h0);
      idle(2900);
      check("measure_led_col", 32'(bus.led_col), 32'h0);
      check("measure_col_idx", 32'(bus.col_idx), 32'h0);
      idle(3000);

      // R6: back in RUN, then asynchronous reset during column 30
      pulse_hi();
      idle(46);
      check("rev_period_r6", 32'(bus.rev_period), 32'd6000);
      push(0, 16'h3FFF);
      push(15, 16'h03FF);
      push(30, 16'hFFFF);
      idle(3054);
      check("pre_reset_col_idx", 32'(bus.col_idx), 32'd30);
      rst_n = 1'b0;
      #1;
      check("async_led_col", 32'(bus.led_col), 32'h0);
      check("async_stalled", 32'(bus.stalled), 32'h1);
      check("async_col_idx", 32'(bus.col_idx), 32'h0);
      idle(5);
      rst_n = 1'b1;
      idle(5);

      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
